// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and constants for the round-robin mux arbiter slice.
// Holds the channel index type, channel count and output-register state encodings.
package rr_mux_arbiter_pkg;

    localparam int NUM_CH = 4;

    typedef logic [1:0] ch_idx_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // Binary index of a one-hot vector; an all-zero vector maps to 0.
    function automatic ch_idx_t onehot_to_idx(input logic [NUM_CH-1:0] oh);
        ch_idx_t idx;
        idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (oh[i]) begin
                idx = ch_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Request/grant and output handshake bundle between requesters, mux and arbiter.
// The master modport is the arbiter's view; slave is the requester/consumer view.
interface rr_mux_arbiter_if #(
    parameter int N = 4
);
    import rr_mux_arbiter_pkg::*;

    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] gnt;
    ch_idx_t           sel;
    logic [N-1:0]      mux_out;
    logic [N-1:0]      out_data;
    logic              out_valid;
    logic              out_ready;
    ch_idx_t           out_ch;

    modport master (
        input  req,
        input  mux_out,
        input  out_ready,
        output gnt,
        output sel,
        output out_data,
        output out_valid,
        output out_ch
    );

    modport slave (
        output req,
        output mux_out,
        output out_ready,
        input  gnt,
        input  sel,
        input  out_data,
        input  out_valid,
        input  out_ch
    );

endinterface

// File: rtl/mux_4x1_param.sv
// Parametric 4:1 word multiplexer steered by the arbiter's select.
module mux_4x1_param #(
    parameter int N = 4
) (
    input  logic [N-1:0] in0_i,
    input  logic [N-1:0] in1_i,
    input  logic [N-1:0] in2_i,
    input  logic [N-1:0] in3_i,
    input  logic [1:0]   sel_i,
    output logic [N-1:0] out_o
);

    always_comb begin
        out_o = in0_i;
        case (sel_i)
            2'd0:    out_o = in0_i;
            2'd1:    out_o = in1_i;
            2'd2:    out_o = in2_i;
            default: out_o = in3_i;
        endcase
    end

endmodule

// File: rtl/rr_mux_arbiter_prio_pick.sv
// Rotating-priority picker: first requesting channel after 'last', wrapping modulo 4.
module rr_prio_pick
    import rr_mux_arbiter_pkg::*;
(
    input  logic [NUM_CH-1:0] req_i,
    input  ch_idx_t           last_i,
    output logic [NUM_CH-1:0] gnt_o
);

    ch_idx_t idx;
    logic    found;

    // Offset NUM_CH lands back on 'last', so a lone requester is still picked.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = last_i + ch_idx_t'(i);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin 4-channel arbiter with bounded bursts, driving the mux select and
// capturing the selected word in a single-entry valid/ready output register.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int BURST = 1
) (
    input logic              clk,
    input logic              rst,
    rr_mux_arbiter_if.master bus
);

    localparam logic [3:0] BURST_LIM = 4'(BURST - 1);

    state_e            state_q, state_d;
    ch_idx_t           last_q, last_d;
    logic              have_last_q, have_last_d;
    logic [3:0]        burst_cnt_q, burst_cnt_d;
    logic [N-1:0]      out_data_q, out_data_d;
    ch_idx_t           out_ch_q, out_ch_d;

    logic              can_load;
    logic              burst_hold;
    logic              grant_any;
    logic [NUM_CH-1:0] rr_gnt;
    logic [NUM_CH-1:0] gnt;
    ch_idx_t           gnt_idx;

    rr_prio_pick u_pick (
        .req_i  (bus.req),
        .last_i (last_q),
        .gnt_o  (rr_gnt)
    );

    // Burst hold needs a real previous grant; right after reset 'last' only seeds the rotation.
    always_comb begin
        can_load   = (state_q == EMPTY) || bus.out_ready;
        burst_hold = have_last_q && (burst_cnt_q < BURST_LIM) && bus.req[last_q];
        gnt        = '0;
        if (can_load && (bus.req != '0)) begin
            if (burst_hold) begin
                gnt[last_q] = 1'b1;
            end else begin
                gnt = rr_gnt;
            end
        end
        grant_any = |gnt;
        gnt_idx   = onehot_to_idx(gnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (grant_any) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (!grant_any && bus.out_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        bus.out_valid = (state_q == FULL);
        bus.gnt       = gnt;
        bus.sel       = gnt_idx;
        bus.out_data  = out_data_q;
        bus.out_ch    = out_ch_q;
    end

    // A new word can replace a draining one on the same edge, so loads ignore state.
    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        last_d      = last_q;
        have_last_d = have_last_q;
        burst_cnt_d = burst_cnt_q;
        if (grant_any) begin
            out_data_d  = bus.mux_out;
            out_ch_d    = gnt_idx;
            last_d      = gnt_idx;
            have_last_d = 1'b1;
            if (have_last_q && (gnt_idx == last_q)) begin
                burst_cnt_d = (burst_cnt_q >= BURST_LIM) ? BURST_LIM : burst_cnt_q + 4'd1;
            end else begin
                burst_cnt_d = 4'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            last_q      <= 2'd3;
            have_last_q <= 1'b0;
            burst_cnt_q <= 4'd0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            last_q      <= last_d;
            have_last_q <= have_last_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed and randomized bench for rr_mux_arbiter with BURST=1 and BURST=3 instances,
// each wired through its own mux_4x1_param.
module tb_rr_mux_arbiter;
    import rr_mux_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] req1, req3;
    logic ready1, ready3;
    logic [3:0] din1 [4];
    logic [3:0] din3 [4];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    rr_mux_arbiter_if #(.N(4)) if1 ();
    rr_mux_arbiter_if #(.N(4)) if3 ();

    assign if1.req       = req1;
    assign if1.out_ready = ready1;
    assign if3.req       = req3;
    assign if3.out_ready = ready3;

    mux_4x1_param #(.N(4)) mux1 (
        .in0_i(din1[0]), .in1_i(din1[1]), .in2_i(din1[2]), .in3_i(din1[3]),
        .sel_i(if1.sel), .out_o(if1.mux_out)
    );
    mux_4x1_param #(.N(4)) mux3 (
        .in0_i(din3[0]), .in1_i(din3[1]), .in2_i(din3[2]), .in3_i(din3[3]),
        .sel_i(if3.sel), .out_o(if3.mux_out)
    );

    rr_mux_arbiter #(.N(4), .BURST(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    rr_mux_arbiter #(.N(4), .BURST(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

    // Sampling and driving both happen 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input logic [3:0] r);
        req1 = r;
        req3 = r;
    endtask

    task automatic setReady(input logic r);
        ready1 = r;
        ready3 = r;
    endtask

    task automatic setDin(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        din1[0] = a; din1[1] = b; din1[2] = c; din1[3] = d;
        din3[0] = a; din3[1] = b; din3[2] = c; din3[3] = d;
    endtask

    task automatic doReset();
        rst = 1'b1;
        setReq(4'b0000);
        setReady(1'b1);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        setReq(4'b0000);
        setReady(1'b1);
        tick();
        tick();
        total++; if (if1.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid1 got=%b want=0", if1.out_valid); end
        total++; if (if1.out_data !== 4'h0) begin bad++; $display("FAIL reset_data1 got=%h want=0", if1.out_data); end
        total++; if (if1.out_ch !== 2'd0) begin bad++; $display("FAIL reset_ch1 got=%0d want=0", if1.out_ch); end
        total++; if (if3.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid3 got=%b want=0", if3.out_valid); end
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            total++; if (if1.gnt !== 4'b0000) begin bad++; $display("FAIL idle_gnt cyc=%0d got=%b want=0000", c, if1.gnt); end
            total++; if (if1.sel !== 2'd0) begin bad++; $display("FAIL idle_sel cyc=%0d got=%0d want=0", c, if1.sel); end
            total++; if (if1.out_valid !== 1'b0) begin bad++; $display("FAIL idle_valid cyc=%0d got=%b want=0", c, if1.out_valid); end
            tick();
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] expG;
        doReset();
        setDin(4'h1, 4'h2, 4'h3, 4'h4);
        setReq(4'b1111);
        setReady(1'b1);
        for (int c = 0; c < 8; c++) begin
            #1;
            expG = 4'b0001 << (c % 4);
            total++; if (if1.gnt !== expG) begin bad++; $display("FAIL rr_gnt cyc=%0d got=%b want=%b", c, if1.gnt, expG); end
            total++; if (if1.sel !== 2'(c % 4)) begin bad++; $display("FAIL rr_sel cyc=%0d got=%0d want=%0d", c, if1.sel, c % 4); end
            tick();
            total++; if (if1.out_valid !== 1'b1) begin bad++; $display("FAIL rr_valid cyc=%0d got=%b want=1", c, if1.out_valid); end
            total++; if (if1.out_data !== 4'((c % 4) + 1)) begin bad++; $display("FAIL rr_data cyc=%0d got=%h want=%0d", c, if1.out_data, (c % 4) + 1); end
            total++; if (if1.out_ch !== 2'(c % 4)) begin bad++; $display("FAIL rr_ch cyc=%0d got=%0d want=%0d", c, if1.out_ch, c % 4); end
        end
        setReq(4'b0000);
        #1;
        total++; if (if1.gnt !== 4'b0000) begin bad++; $display("FAIL rr_drain_gnt got=%b want=0000", if1.gnt); end
        tick();
        total++; if (if1.out_valid !== 1'b0) begin bad++; $display("FAIL rr_drain_valid got=%b want=0", if1.out_valid); end
    endtask

    task automatic test_stall();
        doReset();
        setDin(4'h1, 4'h2, 4'h3, 4'h4);
        setReq(4'b0101);
        setReady(1'b0);
        #1;
        total++; if (if1.gnt !== 4'b0001) begin bad++; $display("FAIL stall_first_gnt got=%b want=0001", if1.gnt); end
        tick();
        total++; if (if1.out_data !== 4'h1 || if1.out_valid !== 1'b1) begin bad++; $display("FAIL stall_first_word got=%h/%b want=1/1", if1.out_data, if1.out_valid); end
        setReq(4'b0100);
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (if1.gnt !== 4'b0000 || if1.sel !== 2'd0) begin bad++; $display("FAIL stall_gnt cyc=%0d got=%b/%0d want=0000/0", c, if1.gnt, if1.sel); end
            tick();
            total++; if (if1.out_data !== 4'h1 || if1.out_ch !== 2'd0 || if1.out_valid !== 1'b1) begin
                bad++; $display("FAIL stall_hold cyc=%0d got=%h/%0d/%b want=1/0/1", c, if1.out_data, if1.out_ch, if1.out_valid);
            end
        end
        setReady(1'b1);
        #1;
        total++; if (if1.gnt !== 4'b0100 || if1.sel !== 2'd2) begin bad++; $display("FAIL stall_release_gnt got=%b/%0d want=0100/2", if1.gnt, if1.sel); end
        tick();
        total++; if (if1.out_data !== 4'h3 || if1.out_ch !== 2'd2 || if1.out_valid !== 1'b1) begin
            bad++; $display("FAIL stall_swap got=%h/%0d/%b want=3/2/1", if1.out_data, if1.out_ch, if1.out_valid);
        end
        setReq(4'b0000);
        tick();
        total++; if (if1.out_valid !== 1'b0) begin bad++; $display("FAIL stall_empty got=%b want=0", if1.out_valid); end
    endtask

    task automatic test_burst();
        ch_idx_t p3 [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
        ch_idx_t p1 [8] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
        ch_idx_t q3 [4] = '{2'd1, 2'd1, 2'd1, 2'd0};
        ch_idx_t q1 [4] = '{2'd1, 2'd0, 2'd1, 2'd0};
        doReset();
        setDin(4'h1, 4'h2, 4'h3, 4'h4);
        setReq(4'b0011);
        setReady(1'b1);
        for (int c = 0; c < 8; c++) begin
            tick();
            total++; if (if3.out_ch !== p3[c]) begin bad++; $display("FAIL burst3_ch cyc=%0d got=%0d want=%0d", c, if3.out_ch, p3[c]); end
            total++; if (if1.out_ch !== p1[c]) begin bad++; $display("FAIL burst1_ch cyc=%0d got=%0d want=%0d", c, if1.out_ch, p1[c]); end
        end
        setReq(4'b0001);
        for (int c = 0; c < 6; c++) begin
            #1;
            total++; if (if3.gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt cyc=%0d got=%b want=0001", c, if3.gnt); end
            tick();
            total++; if (if3.out_ch !== 2'd0 || if3.out_valid !== 1'b1) begin bad++; $display("FAIL single_ch cyc=%0d got=%0d/%b want=0/1", c, if3.out_ch, if3.out_valid); end
        end
        setReq(4'b0011);
        for (int c = 0; c < 4; c++) begin
            tick();
            total++; if (if3.out_ch !== q3[c]) begin bad++; $display("FAIL sat3_ch cyc=%0d got=%0d want=%0d", c, if3.out_ch, q3[c]); end
            total++; if (if1.out_ch !== q1[c]) begin bad++; $display("FAIL sat1_ch cyc=%0d got=%0d want=%0d", c, if1.out_ch, q1[c]); end
        end
    endtask

    task automatic test_reset_full();
        doReset();
        setDin(4'h1, 4'h2, 4'h3, 4'h4);
        setReq(4'b0010);
        setReady(1'b0);
        tick();
        total++; if (if1.out_data !== 4'h2 || if1.out_valid !== 1'b1 || if1.out_ch !== 2'd1) begin
            bad++; $display("FAIL rstfull_load got=%h/%b/%0d want=2/1/1", if1.out_data, if1.out_valid, if1.out_ch);
        end
        setReq(4'b0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (if1.out_valid !== 1'b0 || if1.out_data !== 4'h0 || if1.out_ch !== 2'd0) begin
            bad++; $display("FAIL rstfull_clear got=%b/%h/%0d want=0/0/0", if1.out_valid, if1.out_data, if1.out_ch);
        end
        setReq(4'b1111);
        setReady(1'b1);
        #1;
        total++; if (if1.gnt !== 4'b0001 || if1.sel !== 2'd0) begin bad++; $display("FAIL rstfull_gnt got=%b/%0d want=0001/0", if1.gnt, if1.sel); end
        tick();
        total++; if (if1.out_ch !== 2'd0 || if1.out_data !== 4'h1) begin bad++; $display("FAIL rstfull_word got=%0d/%h want=0/1", if1.out_ch, if1.out_data); end
    endtask

    // Words are tagged {channel, per-channel sequence}; the consumer expects tags in order.
    task automatic test_random(input int which, input int cycles);
        logic [3:0] r, g, od, d [4];
        logic [1:0] seq [4];
        logic [1:0] expSeq [4];
        int waitCnt [4];
        logic rdy, v;
        ch_idx_t oc;
        int k, worst, limit, granted, consumed;
        limit = (which == 3) ? 9 : 3;
        granted = 0;
        consumed = 0;
        r = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            seq[i] = 2'd0; expSeq[i] = 2'd0; waitCnt[i] = 0;
        end
        doReset();
        for (int cyc = 0; cyc < cycles + 20; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (!r[i] && cyc < cycles && $urandom_range(0, 1) == 1) r[i] = 1'b1;
                d[i] = {2'(i), seq[i]};
            end
            rdy = (cyc < cycles) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (which == 3) begin
                req3 = r; ready3 = rdy;
                for (int i = 0; i < 4; i++) din3[i] = d[i];
            end else begin
                req1 = r; ready1 = rdy;
                for (int i = 0; i < 4; i++) din1[i] = d[i];
            end
            #1;
            g  = (which == 3) ? if3.gnt : if1.gnt;
            v  = (which == 3) ? if3.out_valid : if1.out_valid;
            od = (which == 3) ? if3.out_data : if1.out_data;
            oc = (which == 3) ? if3.out_ch : if1.out_ch;
            total++; if ((g & (g - 4'd1)) != 4'b0000) begin bad++; $display("FAIL rnd_onehot dut=%0d cyc=%0d got=%b want=onehot_or_zero", which, cyc, g); end
            total++; if ((g & ~r) != 4'b0000) begin bad++; $display("FAIL rnd_unrequested dut=%0d cyc=%0d got=%b want_subset_of=%b", which, cyc, g, r); end
            k = -1;
            for (int i = 0; i < 4; i++) if (g[i]) k = i;
            if (k >= 0) begin
                granted++;
                for (int i = 0; i < 4; i++) if (r[i] && i != k) waitCnt[i]++;
                waitCnt[k] = 0;
            end
            worst = 0;
            for (int i = 0; i < 4; i++) if (waitCnt[i] > worst) worst = waitCnt[i];
            total++; if (worst > limit) begin bad++; $display("FAIL rnd_fairness dut=%0d cyc=%0d got=%0d want<=%0d", which, cyc, worst, limit); end
            if (v && rdy) begin
                consumed++;
                total++; if (od[3:2] !== oc || od[1:0] !== expSeq[oc]) begin
                    bad++; $display("FAIL rnd_word dut=%0d cyc=%0d got=%h ch=%0d want=%0d%0d", which, cyc, od, oc, oc, expSeq[oc]);
                end
                expSeq[oc] = expSeq[oc] + 2'd1;
            end
            tick();
            if (k >= 0) begin
                r[k] = 1'b0;
                seq[k] = seq[k] + 2'd1;
            end
        end
        total++; if (granted != consumed) begin bad++; $display("FAIL rnd_count dut=%0d got=%0d consumed want=%0d granted", which, consumed, granted); end
        v = (which == 3) ? if3.out_valid : if1.out_valid;
        total++; if (v !== 1'b0) begin bad++; $display("FAIL rnd_drained dut=%0d got=%b want=0", which, v); end
        if (which == 3) req3 = 4'b0000; else req1 = 4'b0000;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1;
        setReq(4'b0000);
        setReady(1'b1);
        setDin(4'h0, 4'h0, 4'h0, 4'h0);
        test_reset();
        test_round_robin();
        test_stall();
        test_burst();
        test_reset_full();
        test_random(1, 5000);
        test_random(3, 5000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
